// File: rtl/calc_pkg.sv
// calc_pkg: shared state encoding, operand width and default timing for
// the calc_sequencer block and its interface.
package calc_pkg;

    localparam int OP_W            = 4;
    localparam int DEF_SPACING     = 4;
    localparam int DEF_HOLD_CYCLES = 1000;
    localparam int DEF_CNT_W       = 16;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RUN  = 3'd1,
        ST_GAP  = 3'd2,
        ST_HOLD = 3'd3,
        ST_ERR  = 3'd4
    } state_e;

    // A command is in flight while the sequencer is in RUN or GAP.
    function automatic logic is_busy_state(input state_e st);
        return (st == ST_RUN) || (st == ST_GAP);
    endfunction

endpackage

// File: rtl/calc_sequencer_if.sv
// calc_sequencer_if: command/status bundle between the button logic, the
// sequencer and the accumulator datapath. The sequencer uses the slave view.
interface calc_sequencer_if;
    import calc_pkg::*;

    logic            go;
    logic            clr;
    logic [OP_W-1:0] addend;
    logic [OP_W-1:0] rep;
    logic            overflow;
    logic [OP_W-1:0] op_addend;
    logic            op_enb;
    logic            calc_clr;
    logic            disp_sum;
    logic            err_led;
    logic            busy;
    logic            done;

    modport master (
        output go, clr, addend, rep, overflow,
        input  op_addend, op_enb, calc_clr, disp_sum, err_led, busy, done
    );

    modport slave (
        input  go, clr, addend, rep, overflow,
        output op_addend, op_enb, calc_clr, disp_sum, err_led, busy, done
    );

endinterface

// File: rtl/seq_timer.sv
// seq_timer: loadable down-counter. Loading N-1 makes expired_o rise in the
// N-th cycle after the load, so one counter serves both GAP and HOLD.
module seq_timer #(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             expired_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: load wins, otherwise count down and park at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/calc_sequencer.sv
// calc_sequencer: sequences repeat-add commands onto the accumulator,
// spacing op_enb pulses and watching the overflow flag.
// Optional build macro CALC_SEQ_QUEUE_EN adds a one-deep pending-command
// buffer for go strobes that arrive while a command is running.
module calc_sequencer
    import calc_pkg::*;
#(
    parameter int SPACING     = DEF_SPACING,
    parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    calc_sequencer_if.slave bus
);

    localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'(SPACING - 1);
    localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_CYCLES - 1);

    state_e          state_q, state_d;
    logic [OP_W-1:0] rem_q, rem_d;
    logic [OP_W-1:0] op_addend_q, op_addend_d;
    logic            op_enb_q, op_enb_d;
    logic            calc_clr_q, calc_clr_d;
    logic            disp_sum_q, disp_sum_d;
    logic            err_led_q, err_led_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic            tmr_load_s;
    logic [CNT_W-1:0] tmr_val_s;
    logic            tmr_expired_s;

    logic            start_valid_s;
    logic [OP_W-1:0] start_addend_s;
    logic [OP_W-1:0] start_rep_s;

    seq_timer #(.CNT_W(CNT_W)) u_timer (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .load_i     (tmr_load_s),
        .load_val_i (tmr_val_s),
        .expired_o  (tmr_expired_s)
    );

`ifdef CALC_SEQ_QUEUE_EN
    logic            pend_valid_q, pend_valid_d;
    logic [OP_W-1:0] pend_addend_q, pend_addend_d;
    logic [OP_W-1:0] pend_rep_q, pend_rep_d;

    // Command source when idle: a buffered command takes precedence over go.
    always_comb begin
        if (pend_valid_q) begin
            start_valid_s  = 1'b1;
            start_addend_s = pend_addend_q;
            start_rep_s    = pend_rep_q;
        end else begin
            start_valid_s  = bus.go;
            start_addend_s = bus.addend;
            start_rep_s    = bus.rep;
        end
    end

    // Pending buffer: capture a go while busy, release on launch, flush on clr/ERR.
    always_comb begin
        pend_valid_d  = pend_valid_q;
        pend_addend_d = pend_addend_q;
        pend_rep_d    = pend_rep_q;
        if (is_busy_state(state_q) && bus.go && !pend_valid_q) begin
            pend_valid_d  = 1'b1;
            pend_addend_d = bus.addend;
            pend_rep_d    = bus.rep;
        end else if (!is_busy_state(state_q) && pend_valid_q) begin
            pend_valid_d = 1'b0;
        end else begin
            pend_valid_d = pend_valid_q;
        end
        if (bus.clr || (state_d == ST_ERR)) begin
            pend_valid_d = 1'b0;
        end else begin
            pend_valid_d = pend_valid_d;
        end
    end

    // Pending buffer registers.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            pend_valid_q  <= 1'b0;
            pend_addend_q <= '0;
            pend_rep_q    <= '0;
        end else begin
            pend_valid_q  <= pend_valid_d;
            pend_addend_q <= pend_addend_d;
            pend_rep_q    <= pend_rep_d;
        end
    end
`else
    // Command source when idle: only a fresh go strobe.
    always_comb begin
        start_valid_s  = bus.go;
        start_addend_s = bus.addend;
        start_rep_s    = bus.rep;
    end
`endif

    // Next state, timer control and next values of all registered outputs.
    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        op_addend_d = op_addend_q;
        done_d      = 1'b0;
        calc_clr_d  = 1'b0;
        tmr_load_s  = 1'b0;
        tmr_val_s   = '0;

        case (state_q)
            ST_IDLE, ST_HOLD: begin
                if (start_valid_s && (start_rep_s != '0)) begin
                    op_addend_d = start_addend_s;
                    rem_d       = start_rep_s;
                    state_d     = ST_RUN;
                end else begin
                    // A zero-repeat command completes at once without enb.
                    done_d = start_valid_s;
                    if ((state_q == ST_HOLD) && tmr_expired_s) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = state_q;
                    end
                end
            end
            ST_RUN: begin
                rem_d      = rem_q - OP_W'(1);
                state_d    = ST_GAP;
                tmr_load_s = 1'b1;
                tmr_val_s  = GAP_LD;
            end
            ST_GAP: begin
                if (bus.overflow) begin
                    rem_d   = '0;
                    state_d = ST_ERR;
                end else if (tmr_expired_s) begin
                    if (rem_q != '0) begin
                        state_d = ST_RUN;
                    end else begin
                        done_d     = 1'b1;
                        state_d    = ST_HOLD;
                        tmr_load_s = 1'b1;
                        tmr_val_s  = HOLD_LD;
                    end
                end else begin
                    state_d = ST_GAP;
                end
            end
            ST_ERR: begin
                state_d = ST_ERR;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // clr overrides everything, including a coincident go.
        if (bus.clr) begin
            state_d     = ST_IDLE;
            rem_d       = '0;
            op_addend_d = op_addend_q;
            done_d      = 1'b0;
            calc_clr_d  = 1'b1;
        end else begin
            calc_clr_d  = 1'b0;
        end

        // Outputs follow the state being entered so they register alongside it.
        op_enb_d  = (state_d == ST_RUN);
        busy_d    = is_busy_state(state_d);
        err_led_d = (state_d == ST_ERR);
        case (state_d)
            ST_HOLD, ST_ERR: disp_sum_d = 1'b1;
            ST_RUN, ST_GAP:  disp_sum_d = disp_sum_q;
            default:         disp_sum_d = 1'b0;
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            rem_q       <= '0;
            op_addend_q <= '0;
            op_enb_q    <= 1'b0;
            calc_clr_q  <= 1'b0;
            disp_sum_q  <= 1'b0;
            err_led_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            op_addend_q <= op_addend_d;
            op_enb_q    <= op_enb_d;
            calc_clr_q  <= calc_clr_d;
            disp_sum_q  <= disp_sum_d;
            err_led_q   <= err_led_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign bus.op_addend = op_addend_q;
    assign bus.op_enb    = op_enb_q;
    assign bus.calc_clr  = calc_clr_q;
    assign bus.disp_sum  = disp_sum_q;
    assign bus.err_led   = err_led_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// tb_calc_sequencer: directed stimulus against a timeline model of the
// sequencer (commands as arithmetic schedules of enb/done cycles), checked
// every cycle, plus literal cycle-offset checks for key scenarios.
module tb_calc_sequencer;
    import calc_pkg::*;

    localparam int S = 4;
    localparam int H = 12;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    calc_sequencer_if bus();

    calc_sequencer #(.SPACING(S), .HOLD_CYCLES(H), .CNT_W(16)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    int ntests = 0;
    int nfail  = 0;
    int cyc    = 0;

    // Model: a command is a schedule starting at m_base with m_rep enb pulses.
    bit       m_active, m_err, m_keep, m_done_nx, m_clr_nx, m_pv;
    int       m_base, m_rep, m_hold_end;
    logic [3:0] m_addend, m_pa, m_pr;

    int enb_log[$];
    int done_log[$];
    int clr_log[$];

    task automatic cmp(input string name, input logic [3:0] got, input logic [3:0] exp);
        ntests++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL cyc=%0d %s got=%0h exp=%0h", cyc, name, got, exp);
        end
    endtask

    task automatic cmp_int(input string name, input int got, input int exp);
        ntests++;
        if (got != exp) begin
            nfail++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    task automatic model_update();
        int c;
        bit in_gap, finish, launch;
        logic [3:0] la, lr;
        c = cyc;
        m_done_nx = 1'b0;
        m_clr_nx  = 1'b0;
        if (!rst_n) begin
            m_active = 0; m_err = 0; m_keep = 0; m_pv = 0;
            m_hold_end = 0; m_base = 0; m_rep = 0; m_addend = 4'd0;
        end else if (bus.clr) begin
            m_active = 0; m_err = 0; m_keep = 0; m_pv = 0;
            m_hold_end = 0; m_clr_nx = 1;
        end else if (m_err) begin
            m_err = 1;
        end else if (m_active && (c >= m_base)) begin
            in_gap = (c > m_base) && (((c - m_base) % (S + 1)) != 0);
            finish = (c == m_base + m_rep * (S + 1) - 1);
            if (bus.overflow && in_gap) begin
                m_err = 1; m_active = 0; m_pv = 0; m_hold_end = 0;
            end else begin
`ifdef CALC_SEQ_QUEUE_EN
                if (bus.go && !m_pv) begin
                    m_pv = 1; m_pa = bus.addend; m_pr = bus.rep;
                end
`endif
                if (finish) begin
                    m_done_nx  = 1;
                    m_active   = 0;
                    m_hold_end = c + 1 + H;
                end
            end
        end else begin
            launch = bus.go; la = bus.addend; lr = bus.rep;
`ifdef CALC_SEQ_QUEUE_EN
            if (m_pv) begin
                launch = 1; la = m_pa; lr = m_pr; m_pv = 0;
            end
`endif
            if (launch) begin
                if (lr != 4'd0) begin
                    m_keep     = (c < m_hold_end);
                    m_hold_end = 0;
                    m_active   = 1;
                    m_base     = c + 1;
                    m_rep      = int'(lr);
                    m_addend   = la;
                end else begin
                    m_done_nx = 1;
                end
            end
        end
    endtask

    task automatic check();
        int n;
        bit e_enb, e_busy, e_disp;
        n = cyc;
        e_enb  = m_active && (n >= m_base) && (((n - m_base) % (S + 1)) == 0)
                 && (((n - m_base) / (S + 1)) < m_rep);
        e_busy = m_active && (n >= m_base);
        e_disp = m_err || (n < m_hold_end) || (m_active && m_keep);
        cmp("op_enb",    {3'd0, bus.op_enb},   {3'd0, e_enb});
        cmp("busy",      {3'd0, bus.busy},     {3'd0, e_busy});
        cmp("disp_sum",  {3'd0, bus.disp_sum}, {3'd0, e_disp});
        cmp("err_led",   {3'd0, bus.err_led},  {3'd0, m_err});
        cmp("done",      {3'd0, bus.done},     {3'd0, m_done_nx});
        cmp("calc_clr",  {3'd0, bus.calc_clr}, {3'd0, m_clr_nx});
        cmp("op_addend", bus.op_addend,        m_addend);
        if (bus.op_enb === 1'b1) enb_log.push_back(cyc);
        if (bus.done === 1'b1) done_log.push_back(cyc);
        if (bus.calc_clr === 1'b1) clr_log.push_back(cyc);
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        cyc = cyc + 1;
        @(negedge clk);
        check();
    endtask

    task automatic steps(input int k);
        for (int i = 0; i < k; i++) step();
    endtask

    task automatic run_until(input int target);
        while (cyc < target) step();
    endtask

    task automatic clear_logs();
        enb_log.delete();
        done_log.delete();
        clr_log.delete();
    endtask

    task automatic pulse_go(input logic [3:0] a, input logic [3:0] r);
        bus.go = 1'b1; bus.addend = a; bus.rep = r;
        step();
        bus.go = 1'b0;
    endtask

    function automatic int log_at(input int q[$], input int i, input int base);
        if (q.size() > i) return q[i] - base;
        return -1;
    endfunction

    int t;
    int exp_enb[4];

    initial begin
        rst_n = 1'b0;
        bus.go = 1'b1; bus.clr = 1'b0; bus.addend = 4'd5; bus.rep = 4'd3;
        bus.overflow = 1'b0;

        // Reset held with go asserted: everything stays zero.
        clear_logs();
        steps(2);
        rst_n = 1'b1; bus.go = 1'b0;
        steps(2);
        cmp_int("reset_no_enb", enb_log.size(), 0);

        // Basic command: addend=3, rep=4.
        clear_logs();
        t = cyc;
        pulse_go(4'd3, 4'd4);
        steps(39);
        exp_enb[0] = 1; exp_enb[1] = 6; exp_enb[2] = 11; exp_enb[3] = 16;
        cmp_int("basic_enb_count", enb_log.size(), 4);
        for (int i = 0; i < 4; i++) cmp_int("basic_enb_cycle", log_at(enb_log, i, t), exp_enb[i]);
        cmp_int("basic_done_cycle", log_at(done_log, 0, t), 21);

        // Zero repeat: single done, no enb.
        clear_logs();
        t = cyc;
        pulse_go(4'd7, 4'd0);
        steps(4);
        cmp_int("rep0_enb_count", enb_log.size(), 0);
        cmp_int("rep0_done_cycle", log_at(done_log, 0, t), 1);
        cmp_int("rep0_done_count", done_log.size(), 1);

        // Overflow after the second enb.
        clear_logs();
        t = cyc;
        pulse_go(4'd15, 4'd3);
        run_until(t + 7);
        bus.overflow = 1'b1;
        steps(3);
        pulse_go(4'd1, 4'd1);
        steps(2);
        bus.clr = 1'b1; bus.overflow = 1'b0;
        step();
        bus.clr = 1'b0;
        steps(3);
        cmp_int("ovf_enb_count", enb_log.size(), 2);
        cmp_int("ovf_done_count", done_log.size(), 0);
        cmp_int("ovf_clr_count", clr_log.size(), 1);

        // go coincident with clr in IDLE is dropped.
        clear_logs();
        bus.clr = 1'b1;
        pulse_go(4'd9, 4'd2);
        bus.clr = 1'b0;
        steps(8);
        cmp_int("goclr_enb_count", enb_log.size(), 0);

        // clr in the middle of a GAP.
        clear_logs();
        t = cyc;
        pulse_go(4'd4, 4'd3);
        run_until(t + 3);
        bus.clr = 1'b1;
        step();
        bus.clr = 1'b0;
        steps(12);
        cmp_int("gapclr_enb_count", enb_log.size(), 1);
        cmp_int("gapclr_clr_cycle", log_at(clr_log, 0, t), 4);

        // go while busy.
        clear_logs();
        t = cyc;
        pulse_go(4'd1, 4'd2);
        run_until(t + 3);
        pulse_go(4'd2, 4'd1);
        steps(30);
        cmp_int("busy_first_done", log_at(done_log, 0, t), 11);
`ifdef CALC_SEQ_QUEUE_EN
        cmp_int("busy_enb_count", enb_log.size(), 3);
        cmp_int("busy_queued_enb", log_at(enb_log, 2, t), 12);
        cmp_int("busy_second_done", log_at(done_log, 1, t), 17);
`else
        cmp_int("busy_enb_count", enb_log.size(), 2);
        cmp_int("busy_done_count", done_log.size(), 1);
`endif

        // Restart from HOLD keeps the sum displayed.
        clear_logs();
        t = cyc;
        pulse_go(4'd6, 4'd1);
        run_until(t + 8);
        pulse_go(4'd2, 4'd2);
        steps(35);
        cmp_int("hold_restart_enb", log_at(enb_log, 1, t), 9);
        cmp_int("hold_restart_done", log_at(done_log, 1, t), 19);

        // Reset mid-command aborts silently.
        clear_logs();
        pulse_go(4'd8, 4'd3);
        steps(3);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        steps(6);
        cmp_int("rstmid_clr_count", clr_log.size(), 0);
        cmp_int("rstmid_enb_count", enb_log.size(), 1);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
